// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-phase fetch controller (in: clk, rst_n, stall, branch_valid, branch_target, halt_req; out: counter, pc, halted, fault, retired_count)
module fetch_sequencer #(
  parameter int NUM_PHASES = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  input  logic        halt_req,
  output logic [2:0]  counter,
  output logic [31:0] pc,
  output logic        halted,
  output logic [1:0]  fault,
  output logic [31:0] retired_count
);
  typedef enum logic {RUN, HALT} state_t;
  localparam logic [2:0] LAST = 3'(NUM_PHASES - 1);
  localparam logic [32:0] LIMIT = 33'(4 * IMEM_DEPTH);
  state_t state, state_d;
  logic [2:0] counter_d;
  logic [31:0] pc_d, ret_d, br_tgt, br_tgt_d, next_pc;
  logic [1:0] fault_d;
  logic br_pend, br_pend_d, halt_pend, halt_pend_d, take, wrap, mis, bad, stop;
  assign halted = state == HALT;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      counter <= 3'd0;
      pc <= RESET_PC;
      fault <= 2'd0;
      retired_count <= 32'd0;
      br_pend <= 1'b0;
      br_tgt <= 32'd0;
      halt_pend <= 1'b0;
    end else begin
      state <= state_d;
      counter <= counter_d;
      pc <= pc_d;
      fault <= fault_d;
      retired_count <= ret_d;
      br_pend <= br_pend_d;
      br_tgt <= br_tgt_d;
      halt_pend <= halt_pend_d;
    end
  always_comb begin
    take = state == RUN && branch_valid && counter != 3'd0;
    next_pc = take ? branch_target : br_pend ? br_tgt : pc + 32'd4;
    mis = |next_pc[1:0];
    bad = mis || {1'b0, next_pc} >= LIMIT;
    wrap = state == RUN && !stall && counter == LAST;
    stop = bad || halt_pend || halt_req;
    state_d = wrap && stop ? HALT : state;
    counter_d = state == HALT || stall ? counter : wrap ? (stop ? 3'd7 : 3'd0) : counter + 3'd1;
    pc_d = wrap && !bad ? next_pc : pc;
    ret_d = wrap ? retired_count + 32'd1 : retired_count;
    fault_d = !wrap ? fault : mis ? 2'd1 : bad ? 2'd2 : 2'd0;
    br_pend_d = !wrap && (br_pend || take);
    br_tgt_d = take ? branch_target : br_tgt;
    halt_pend_d = !wrap && (halt_pend || (halt_req && state == RUN));
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle fetch controller directly upstream of the instruction memory. Drives the 3-bit phase `counter` and byte-address `pc` that the instruction memory samples; the memory latches `inst` at posedge when `counter == 0`.
- Steps each instruction through NUM_PHASES phases: IF, ID, EX, MEM, WB.
- Applies sequential increment or branch/jump redirect at instruction end; halts on request or fault.

Parameters:
- NUM_PHASES, 5, phases per instruction; legal 2..7; phase codes 0..NUM_PHASES-1.
- RESET_PC, 32'h0000_0000, pc after reset; must be word-aligned.
- IMEM_DEPTH, 128, instruction memory entries; legal pc range is 0..4*IMEM_DEPTH-4 (byte addressed, word aligned).

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- stall, in, 1, freeze counter and pc this cycle.
- branch_valid, in, 1, redirect request from execute logic.
- branch_target, in, 32, redirect byte address; valid with branch_valid.
- halt_req, in, 1, stop after the current instruction (ecall/ebreak decode).
- counter, out, 3, current phase; 3'd7 = idle (halted).
- pc, out, 32, byte address of the current instruction.
- halted, out, 1, sequencer in HALT state.
- fault, out, 2, 0 = none, 1 = misaligned target, 2 = pc out of range.
- retired_count, out, 32, number of completed instructions.

Behaviour:
- Reset (async assert, sync to clk on deassert):
  - counter=0, pc=RESET_PC, halted=0, fault=0, retired_count=0.
  - pending branch and pending halt cleared; state RUN.
  - First posedge after deassert is an IF edge (counter==0, pc=RESET_PC).
- States: RUN and HALT.
- RUN, stall=1:
  - counter, pc and retired_count hold.
  - branch_valid and halt_req are still captured.
- RUN, stall=0, counter < NUM_PHASES-1: counter increments by 1.
- RUN, stall=0, counter == NUM_PHASES-1 (wrap edge):
  - counter <= 0; retired_count increments (32-bit wrap at 2^32-1 -> 0).
  - next_pc = pending branch target if a branch is pending, else pc+4 (32-bit wrap).
  - Pending branch and halt flags clear.
- Branch capture:
  - branch_valid=1 on any RUN edge with counter != 0 latches branch_target into the pending register.
  - Last capture before the wrap edge wins.
  - branch_valid on the counter==0 edge is ignored.
  - A capture on the wrap edge itself is applied at that same edge; the input has priority over a previously pending target.
- Faults, evaluated on next_pc at the wrap edge:
  - next_pc[1:0] != 0 -> fault=1.
  - Otherwise next_pc >= 4*IMEM_DEPTH -> fault=2.
  - On any fault: pc holds the old value, counter <= 7, halted <= 1, state HALT.
  - The faulting instruction is still counted as retired.
- Halt request:
  - halt_req captured on any RUN edge sets the pending halt flag.
  - At the next wrap edge: pc <= next_pc, counter <= 7, halted <= 1, state HALT, fault=0.
  - If a fault also occurs at that edge, the fault takes priority and fault is set.
- HALT:
  - All outputs hold; counter stays 7 so the instruction memory never re-fetches.
  - Inputs are ignored. Exit only through rst_n.
- Reset mid-instruction: immediately returns to reset values; pending state is lost.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then 3 instructions with no stall/branch -> counter runs 0,1,2,3,4,0,...; pc 0 -> 4 -> 8 at edges 5 and 10; retired_count=3 after 15 cycles.
- branch_valid=1 with target 32'h40 at counter==2 -> pc=32'h40 at wrap; a second branch to 32'h80 at counter==3 in the same instruction -> pc=32'h80 instead.
- stall=1 for 4 cycles at counter==1 -> counter and pc frozen for 4 cycles; instruction completes 4 cycles late; retired_count exact.
- Branch target 32'h42 -> fault=1, halted=1, counter=7, pc unchanged. Target 32'h200 with IMEM_DEPTH=128 -> fault=2.
- halt_req pulse at counter==3 with pc=8 -> at wrap pc=12, counter=7, halted=1, fault=0; no further counter activity for 20 cycles.
- Assert rst_n=0 asynchronously at counter==3 mid-branch -> outputs reset immediately without a clock edge; after release pc=RESET_PC and the pending branch is not applied.
